// File: rtl/uart_pkg.sv
// Shared UART definitions for the host-side transmitter.
// Contents: transmitter FSM state type, data-bit count, idle line level.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    write strobe and data (ignored while full)
//   pop            read strobe (ignored while empty)
//   rdata          head entry, combinational; valid whenever !empty
//   full, empty    status from registered count
//   count          entries held, 0..DEPTH
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: serialises a byte stream onto rxd with
// 8N1 / 8N2 framing, gated by the peer's cts.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   cfg_div          bit period = cfg_div+1 clocks (latched per frame)
//   cfg_two_stop     0: one stop bit, 1: two stop bits (latched per frame)
//   in_valid/in_data/in_ready   byte input, push = in_valid & in_ready
//   cts              peer ready, asynchronous
//   rxd              serial output, idle high, registered
//   busy             frame in progress or FIFO non-empty
//   fifo_count       bytes waiting in the FIFO
module uart_host_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_two_stop,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          cts,
  output logic                          rxd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  logic                      push, pop, full, empty;
  logic [7:0]                head;

  uart_tx_state_t            state_q, state_d;
  logic [DIV_W-1:0]          timer_q, timer_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic                      two_stop_q, two_stop_d;
  logic                      second_stop_q, second_stop_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [7:0]                shift_q, shift_d;
  logic                      rxd_q, rxd_d;
  logic                      cts_meta_q, cts_s_q;
  logic                      bit_end;

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign rxd      = rxd_q;
  assign busy     = (state_q != IDLE) | (fifo_count != '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign bit_end = (timer_q == '0);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    div_d         = div_q;
    two_stop_d    = two_stop_q;
    second_stop_d = second_stop_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        // Frame start: pop head and freeze this frame's configuration.
        if (!empty && cts_s_q) begin
          pop           = 1'b1;
          state_d       = START;
          shift_d       = head;
          div_d         = cfg_div;
          two_stop_d    = cfg_two_stop;
          second_stop_d = 1'b0;
          timer_d       = cfg_div;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          timer_d = div_q;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = div_q;
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            state_d       = STOP;
            second_stop_d = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      STOP: begin
        // Two stop bits are timed as two full bit periods, so the timer
        // never needs to hold 2*(div+1).
        if (bit_end) begin
          if (two_stop_q && !second_stop_q) begin
            second_stop_d = 1'b1;
            timer_d       = div_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so rxd is a clean register output.
    case (state_d)
      START:   rxd_d = ~UART_IDLE_LVL;
      DATA:    rxd_d = shift_d[0];
      default: rxd_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      div_q         <= '0;
      two_stop_q    <= 1'b0;
      second_stop_q <= 1'b0;
      idx_q         <= '0;
      shift_q       <= '0;
      rxd_q         <= UART_IDLE_LVL;
      cts_meta_q    <= 1'b0;
      cts_s_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      div_q         <= div_d;
      two_stop_q    <= two_stop_d;
      second_stop_q <= second_stop_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      rxd_q         <= rxd_d;
      cts_meta_q    <= cts;
      cts_s_q       <= cts_meta_q;
    end
  end

endmodule

// File: tb/tb_uart_host_tx.sv
// Directed bench for uart_host_tx. Expected frames are queued when bytes are
// pushed; a line monitor decodes rxd cycle by cycle and compares against the
// queue head, recording each frame's start cycle for spacing checks.
module tb_uart_host_tx;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         two_stop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_div;
  logic        cfg_two_stop;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cts;
  logic        rxd;
  logic        busy;
  logic [4:0]  fifo_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   frames_done = 0;
  int   exp_frames  = 0;
  int   n_started   = 0;
  int   cur_start   = 0;
  int   last_push_cyc = 0;
  exp_t sb_q[$];
  int   starts[$];

  uart_host_tx dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_div      (cfg_div),
    .cfg_two_stop (cfg_two_stop),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cts          (cts),
    .rxd          (rxd),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_level(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_byte(input logic [7:0] d, input int div, input bit ts);
    int   n = 0;
    exp_t e;
    while (in_ready !== 1'b1 && n < 5000) begin n++; @(negedge clk); end
    check("push_ready", in_ready, 1'b1);
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1; in_data = d;
    e.data = d; e.div = div; e.two_stop = ts;
    sb_q.push_back(e); exp_frames++;
    @(negedge clk);
    in_valid = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic wait_all(input string tag);
    int n = 0;
    while (frames_done != exp_frames && n < 5000) begin n++; @(negedge clk); end
    check(tag, frames_done, exp_frames);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, input int ns0);
    int n = 0;
    while (n_started <= ns0 && n < 5000) begin n++; @(negedge clk); end
    check(tag, n_started > ns0, 1'b1);
  endtask

  // Line monitor / scoreboard consumer.
  initial begin : monitor
    exp_t       e;
    int         per, nbits, errs, s;
    logic [7:0] got;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && rxd === 1'b0) begin
        s = cyc; cur_start = s; n_started++;
        check("sb_frame_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          per = e.div + 1; nbits = e.two_stop ? 11 : 10;
          errs = 0; got = '0; aborted = 1'b0;
          for (int b = 0; b < nbits && !aborted; b++)
            for (int c = 0; c < per && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rstn !== 1'b1) aborted = 1'b1;
              else begin
                if (rxd !== exp_level(e.data, b)) errs++;
                if (b >= 1 && b <= 8 && c == per / 2) got[b-1] = rxd;
              end
            end
          if (!aborted) begin
            starts.push_back(s);
            check("frame_data", got, e.data);
            check("frame_shape_errs", errs, 0);
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   base, ns0, p, cnt, bad, s, raise_cyc;
    exp_t e;
    rstn = 1'b0; cts = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_div = 16'd3; cfg_two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rxd", rxd, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    rstn = 1'b1; cts = 1'b1;
    repeat (4) @(negedge clk);

    // T1: 0x55 at div=3
    base = starts.size();
    push_byte(8'h55, 3, 1'b0);
    p = last_push_cyc;
    check("t1_no_bypass_rxd", rxd, 1'b1);
    check("t1_count_after_push", fifo_count, 1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 500) begin cnt++; @(negedge clk); end
    check("t1_busy_cycles", cnt, 41);
    wait_all("t1_drain");
    check("t1_start_latency", starts[base] - p, 1);

    // T2: back-to-back at div=0
    cfg_div = 16'd0;
    base = starts.size();
    push_byte(8'hA3, 0, 1'b0);
    push_byte(8'h0F, 0, 1'b0);
    wait_all("t2_drain");
    check("t2_start_gap", starts[base+1] - starts[base], 11);

    // T3: fill while cts low, then release
    cfg_div = 16'd1; cts = 1'b0;
    repeat (4) @(negedge clk);
    base = starts.size();
    for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i), 1, 1'b0);
    check("t3_full_in_ready", in_ready, 1'b0);
    check("t3_full_count", fifo_count, 16);
    check("t3_held_rxd", rxd, 1'b1);
    in_valid = 1'b1; in_data = 8'h77;
    e.data = 8'h77; e.div = 1; e.two_stop = 1'b0;
    sb_q.push_back(e); exp_frames++;
    cts = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    check("t3_17th_after_pop_count", fifo_count, 15);
    check("t3_17th_after_pop_rxd", rxd, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("t3_17th_accepted", fifo_count, 16);
    wait_all("t3_drain");
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (starts[base+i+1] - starts[base+i] != 21) bad++;
    check("t3_bad_gaps", bad, 0);

    // T4: two stop bits; config change mid-frame applies to next frame only
    cfg_div = 16'd2; cfg_two_stop = 1'b1;
    base = starts.size(); ns0 = n_started;
    push_byte(8'hFF, 2, 1'b1);
    push_byte(8'h00, 2, 1'b0);
    wait_start("t4_start_seen", ns0);
    s = cur_start;
    while (cyc < s + 10) @(negedge clk);
    cfg_two_stop = 1'b0;
    wait_all("t4_drain");
    check("t4_start_gap", starts[base+1] - starts[base], 34);

    // T5: cts drop mid data bit 3
    cfg_div = 16'd3;
    base = starts.size(); ns0 = n_started;
    push_byte(8'h5A, 3, 1'b0);
    push_byte(8'h3C, 3, 1'b0);
    wait_start("t5_start_seen", ns0);
    s = cur_start;
    while (cyc < s + 17) @(negedge clk);
    cts = 1'b0;
    cnt = 0;
    while (frames_done < exp_frames - 1 && cnt < 500) begin cnt++; @(negedge clk); end
    repeat (30) @(negedge clk);
    check("t5_held_frames", n_started, ns0 + 1);
    check("t5_held_rxd", rxd, 1'b1);
    check("t5_held_count", fifo_count, 1);
    cts = 1'b1; raise_cyc = cyc;
    wait_all("t5_drain");
    check("t5_restart_lat_ok",
          (starts[base+1] - raise_cyc >= 3) && (starts[base+1] - raise_cyc <= 4), 1'b1);

    // T6: async reset mid-frame
    cfg_div = 16'd1;
    ns0 = n_started;
    push_byte(8'h00, 1, 1'b0);
    push_byte(8'h11, 1, 1'b0);
    wait_start("t6_start_seen", ns0);
    s = cur_start;
    while (cyc < s + 8) @(negedge clk);
    check("t6_mid_frame_rxd", rxd, 1'b0);
    #2 rstn = 1'b0;
    #1 check("t6_async_rxd", rxd, 1'b1);
    sb_q.delete();
    exp_frames = frames_done;
    @(negedge clk); @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("t6_count_after", fifo_count, 0);
    check("t6_in_ready_after", in_ready, 1'b1);
    check("t6_busy_after", busy, 1'b0);
    push_byte(8'h96, 1, 1'b0);
    wait_all("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
